release_beat_collector: RTL and testbench
=========================================

RELEASE_BEAT_COLLECTOR -- requirements
Module: release_beat_collector

Interface
REQ-001 Parameter DATA_W, 128, width of one release data beat.
REQ-002 Parameter BEATS, 4, beats per data-carrying release; power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 io_in_valid / io_in_ready  input / output  1 / 1  beat handshake from upstream release arbiter.
REQ-006 io_in_bits_addr_beat  input  log2(BEATS)  beat index.
REQ-007 io_in_bits_addr_block, io_in_bits_client_xact_id, io_in_bits_voluntary, io_in_bits_r_type  input  26, 6, 1, 3  release header.
REQ-008 io_in_bits_data  input  DATA_W  beat payload.
REQ-009 io_out_valid / io_out_ready  output / input  1 / 1  assembled-release handshake.
REQ-010 io_out_bits_addr_block, io_out_bits_client_xact_id, io_out_bits_voluntary, io_out_bits_r_type  output  26, 6, 1, 3  captured header.
REQ-011 io_out_bits_has_data  output  1  release carried data.
REQ-012 io_out_bits_data  output  DATA_W*BEATS  beat k in bits [k*DATA_W +: DATA_W].
REQ-013 io_err  output  1  sticky beat-order error flag.

Function
REQ-014 has_data SHALL be 1 when r_type is 0, 1 or 2, and 0 otherwise.
REQ-015 FSM states SHALL be IDLE, COLLECT and FULL.
REQ-016 io_in_ready SHALL equal (state != FULL) OR io_out_ready.
REQ-017 A beat accepted in IDLE SHALL capture the header and has_data, store its data in slot 0, and set beat counter to 1.
REQ-018 A no-data beat accepted in IDLE SHALL go to FULL with io_out_bits_data all zero.
REQ-019 A data beat accepted in IDLE SHALL go to COLLECT.
REQ-020 Each beat accepted in COLLECT SHALL be written to the slot given by the beat counter, and the counter SHALL then increment.
REQ-021 Header fields of beats after the first SHALL be ignored.
REQ-022 Acceptance of beat BEATS-1 SHALL move the FSM to FULL, with the counter wrapping to 0.
REQ-023 io_out_valid SHALL be 1 exactly in FULL; output fields SHALL stay stable while valid and not ready.
REQ-024 Latency: io_out_valid SHALL rise on the cycle after the final beat is accepted (cycle after the single beat for no-data releases).
REQ-025 Output fire in FULL with no input fire SHALL return the FSM to IDLE.
REQ-026 Simultaneous output fire and input fire in FULL SHALL treat the input beat as a new first beat, as in REQ-017 to REQ-019; there SHALL be no bubble.
REQ-027 No reordering and no beat drop; io_in_valid low in COLLECT SHALL hold state indefinitely.

Reset
REQ-028 reset_n low SHALL immediately force IDLE, beat counter 0, io_out_valid 0, io_err 0, and all captured header and data registers 0.
REQ-029 Reset asserted mid-COLLECT or mid-FULL SHALL discard the partial or pending release.
REQ-030 Reset deassertion SHALL be synchronised externally; after release, io_in_ready SHALL be 1.

Configuration
REQ-031 Macro RELEASE_COLLECT_ORDER_CHECK_EN defined: an accepted data beat whose addr_beat differs from the beat counter SHALL set io_err, which stays set until reset; the beat SHALL still be stored in the counter slot.
REQ-032 Macro RELEASE_COLLECT_ORDER_CHECK_EN undefined: io_err SHALL be tied 0, addr_beat SHALL be unused, and no check logic SHALL be generated.

Structure
REQ-033 Shared package release_pkg SHALL hold r_type encodings, BEATS default, field widths, the has_data function and the state enum typedef.
REQ-034 No sub-module: single flat module; the data store is a BEATS x DATA_W register array.

Verification
REQ-035 r_type=0, 4 back-to-back beats 0x11..,0x22..,0x33..,0x44.., io_out_ready=1 -> io_out_valid on cycle 5, data = {0x44..,0x33..,0x22..,0x11..}, has_data=1.
REQ-036 r_type=4, one beat with data=0xFF.., addr_block=0x2A5 -> next-cycle output with has_data=0, data=0, addr_block=0x2A5.
REQ-037 FULL held with io_out_ready=0 for 5 cycles -> io_in_ready=0 and output stable; raise ready with a new r_type=3 beat present -> both fire same cycle, next cycle outputs the r_type=3 release.
REQ-038 Data release with io_in_valid gaps of 3 cycles between beats -> correct assembly, io_out_valid only after 4th beat.
REQ-039 reset_n pulsed low after 2 of 4 beats -> io_out_valid 0; a subsequent full release assembles with no stale beats.
REQ-040 With RELEASE_COLLECT_ORDER_CHECK_EN, addr_beat sequence 0,2,1,3 -> io_err=1 after second beat and stays 1; without macro -> io_err=0.

Source files
------------

// File: rtl/release_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : release_pkg
//  Description : Shared definitions for the release beat collector: release
//                type encodings, default geometry, header field widths, the
//                header struct, the has_data decode and the FSM state type.
//  Revision    : 1.0  initial release
// ============================================================================
package release_pkg;

    // Default geometry
    localparam int DATA_W_DEFAULT = 128;
    localparam int BEATS_DEFAULT  = 4;

    // Header field widths
    localparam int ADDR_BLOCK_W = 26;
    localparam int XACT_ID_W    = 6;
    localparam int R_TYPE_W     = 3;

    // Release type encodings; the first three carry a data payload
    localparam logic [R_TYPE_W-1:0] RT_INVALIDATE_DATA = 3'd0;
    localparam logic [R_TYPE_W-1:0] RT_DOWNGRADE_DATA  = 3'd1;
    localparam logic [R_TYPE_W-1:0] RT_COPY_DATA       = 3'd2;
    localparam logic [R_TYPE_W-1:0] RT_INVALIDATE_ACK  = 3'd3;
    localparam logic [R_TYPE_W-1:0] RT_DOWNGRADE_ACK   = 3'd4;
    localparam logic [R_TYPE_W-1:0] RT_COPY_ACK        = 3'd5;

    typedef struct packed {
        logic [ADDR_BLOCK_W-1:0] addr_block;
        logic [XACT_ID_W-1:0]    client_xact_id;
        logic                    voluntary;
        logic [R_TYPE_W-1:0]     r_type;
    } release_hdr_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2
    } collect_state_e;

    function automatic logic has_data(input logic [R_TYPE_W-1:0] r_type);
        return (r_type == RT_INVALIDATE_DATA) ||
               (r_type == RT_DOWNGRADE_DATA)  ||
               (r_type == RT_COPY_DATA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/release_beat_collector.sv
`default_nettype none
// ============================================================================
//  Module      : release_beat_collector
//  Description : Collects the beats of a release into one wide output
//                transaction. Data releases take BEATS beats; no-data
//                releases complete on their single beat. A completed release
//                is held on the output until accepted; a new first beat may be
//                accepted in the same cycle the output fires.
//  Ports       : clk, reset_n (async, active low)
//                io_in_*   beat handshake, header, beat index and payload
//                io_out_*  assembled release: header, has_data, BEATS*DATA_W data
//                io_err    sticky beat-order error
//  Options     : RELEASE_COLLECT_ORDER_CHECK_EN - when defined, an accepted
//                data beat whose addr_beat differs from its slot sets io_err
//                until reset. Otherwise io_err is 0 and addr_beat is ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module release_beat_collector
    import release_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int BEATS  = BEATS_DEFAULT
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           io_in_valid,
    output logic                           io_in_ready,
    input  logic [$clog2(BEATS)-1:0]       io_in_bits_addr_beat,
    input  logic [ADDR_BLOCK_W-1:0]        io_in_bits_addr_block,
    input  logic [XACT_ID_W-1:0]           io_in_bits_client_xact_id,
    input  logic                           io_in_bits_voluntary,
    input  logic [R_TYPE_W-1:0]            io_in_bits_r_type,
    input  logic [DATA_W-1:0]              io_in_bits_data,
    output logic                           io_out_valid,
    input  logic                           io_out_ready,
    output logic [ADDR_BLOCK_W-1:0]        io_out_bits_addr_block,
    output logic [XACT_ID_W-1:0]           io_out_bits_client_xact_id,
    output logic                           io_out_bits_voluntary,
    output logic [R_TYPE_W-1:0]            io_out_bits_r_type,
    output logic                           io_out_bits_has_data,
    output logic [DATA_W*BEATS-1:0]        io_out_bits_data,
    output logic                           io_err
);

    localparam int BEAT_W = $clog2(BEATS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    collect_state_e    state_q, state_d;
    logic [BEAT_W-1:0] cnt_q, cnt_d;
    release_hdr_t      hdr_q, hdr_d;
    logic              has_data_q, has_data_d;
    logic [DATA_W-1:0] data_q [BEATS];
    logic [DATA_W-1:0] data_d [BEATS];

    logic in_fire;
    logic out_fire;
    logic in_has_data;
    logic take_first;   // accepted beat starts a new release
    logic take_next;    // accepted beat continues the release in progress

    assign io_in_ready  = (state_q != ST_FULL) || io_out_ready;
    assign io_out_valid = (state_q == ST_FULL);
    assign in_fire      = io_in_valid && io_in_ready;
    assign out_fire     = io_out_valid && io_out_ready;
    assign in_has_data  = has_data(io_in_bits_r_type);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hdr_d      = hdr_q;
        has_data_d = has_data_q;
        take_first = 1'b0;
        take_next  = 1'b0;
        for (int k = 0; k < BEATS; k++) begin
            data_d[k] = data_q[k];
        end

        case (state_q)
            ST_IDLE: begin
                take_first = in_fire;
            end
            ST_COLLECT: begin
                take_next = in_fire;
            end
            ST_FULL: begin
                // Output fire frees the register set; a concurrent beat is
                // the first beat of the next release, so no bubble.
                if (out_fire) begin
                    if (in_fire) begin
                        take_first = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take_first) begin
            hdr_d.addr_block     = io_in_bits_addr_block;
            hdr_d.client_xact_id = io_in_bits_client_xact_id;
            hdr_d.voluntary      = io_in_bits_voluntary;
            hdr_d.r_type         = io_in_bits_r_type;
            has_data_d           = in_has_data;
            cnt_d                = BEAT_W'(1);
            // Clear every slot so a no-data release presents all-zero data
            // and nothing from the previous release can leak through.
            for (int k = 0; k < BEATS; k++) begin
                data_d[k] = '0;
            end
            if (in_has_data) begin
                data_d[0] = io_in_bits_data;
                state_d   = ST_COLLECT;
            end else begin
                state_d   = ST_FULL;
            end
        end

        if (take_next) begin
            data_d[cnt_q] = io_in_bits_data;
            cnt_d         = cnt_q + BEAT_W'(1);   // wraps to 0 after last beat
            if (cnt_q == LAST_BEAT) begin
                state_d = ST_FULL;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            hdr_q      <= '0;
            has_data_q <= 1'b0;
            for (int k = 0; k < BEATS; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hdr_q      <= hdr_d;
            has_data_q <= has_data_d;
            for (int k = 0; k < BEATS; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign io_out_bits_addr_block     = hdr_q.addr_block;
    assign io_out_bits_client_xact_id = hdr_q.client_xact_id;
    assign io_out_bits_voluntary      = hdr_q.voluntary;
    assign io_out_bits_r_type         = hdr_q.r_type;
    assign io_out_bits_has_data       = has_data_q;

    genvar gk;
    generate
        for (gk = 0; gk < BEATS; gk++) begin : g_out_data
            assign io_out_bits_data[gk*DATA_W +: DATA_W] = data_q[gk];
        end
    endgenerate

`ifdef RELEASE_COLLECT_ORDER_CHECK_EN
    logic err_q, err_d;

    // A first data beat belongs in slot 0 regardless of where the counter
    // was left by a preceding no-data release.
    always_comb begin
        err_d = err_q;
        if (take_first && in_has_data && (io_in_bits_addr_beat != '0)) begin
            err_d = 1'b1;
        end
        if (take_next && (io_in_bits_addr_beat != cnt_q)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign io_err = err_q;
`else
    logic unused_addr_beat;
    assign unused_addr_beat = ^io_in_bits_addr_beat;
    assign io_err           = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_release_beat_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_release_beat_collector
//  Description : Self-checking bench for release_beat_collector. A
//                transaction-level model assembles expected releases from the
//                beats it knows were accepted and compares every output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_release_beat_collector;
    import release_pkg::*;

    localparam int DATA_W = 128;
    localparam int BEATS  = 4;
    localparam int BW     = $clog2(BEATS);
    localparam int OW     = DATA_W * BEATS;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              io_in_valid = 1'b0;
    logic              io_in_ready;
    logic [BW-1:0]     io_in_bits_addr_beat = '0;
    logic [25:0]       io_in_bits_addr_block = '0;
    logic [5:0]        io_in_bits_client_xact_id = '0;
    logic              io_in_bits_voluntary = 1'b0;
    logic [2:0]        io_in_bits_r_type = '0;
    logic [DATA_W-1:0] io_in_bits_data = '0;
    logic              io_out_valid;
    logic              io_out_ready = 1'b0;
    logic [25:0]       io_out_bits_addr_block;
    logic [5:0]        io_out_bits_client_xact_id;
    logic              io_out_bits_voluntary;
    logic [2:0]        io_out_bits_r_type;
    logic              io_out_bits_has_data;
    logic [OW-1:0]     io_out_bits_data;
    logic              io_err;

    always #5 clk = ~clk;

    release_beat_collector #(.DATA_W(DATA_W), .BEATS(BEATS)) dut (
        .clk                        (clk),
        .reset_n                    (reset_n),
        .io_in_valid                (io_in_valid),
        .io_in_ready                (io_in_ready),
        .io_in_bits_addr_beat       (io_in_bits_addr_beat),
        .io_in_bits_addr_block      (io_in_bits_addr_block),
        .io_in_bits_client_xact_id  (io_in_bits_client_xact_id),
        .io_in_bits_voluntary       (io_in_bits_voluntary),
        .io_in_bits_r_type          (io_in_bits_r_type),
        .io_in_bits_data            (io_in_bits_data),
        .io_out_valid               (io_out_valid),
        .io_out_ready               (io_out_ready),
        .io_out_bits_addr_block     (io_out_bits_addr_block),
        .io_out_bits_client_xact_id (io_out_bits_client_xact_id),
        .io_out_bits_voluntary      (io_out_bits_voluntary),
        .io_out_bits_r_type         (io_out_bits_r_type),
        .io_out_bits_has_data       (io_out_bits_has_data),
        .io_out_bits_data           (io_out_bits_data),
        .io_err                     (io_err)
    );

    typedef struct {
        logic [25:0]   blk;
        logic [5:0]    xid;
        logic          vol;
        logic [2:0]    rt;
        logic          hd;
        logic [OW-1:0] data;
    } rel_t;

    rel_t exp_q[$];     // completed releases awaiting output (at most one)
    rel_t cur;          // release being assembled
    int   cur_cnt = 0;  // beats of cur received; 0 means none in progress
    logic err_exp = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rand_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Apply one accepted beat to the model.
    task automatic model_beat(input logic [25:0] blk, input logic [5:0] xid, input logic vol,
                              input logic [2:0] rt, input logic [BW-1:0] ab,
                              input logic [DATA_W-1:0] d);
        logic hd;
        hd = (rt <= 3'd2);
        if (cur_cnt == 0) begin
            cur.blk  = blk;
            cur.xid  = xid;
            cur.vol  = vol;
            cur.rt   = rt;
            cur.hd   = hd;
            cur.data = '0;
            if (hd) begin
`ifdef RELEASE_COLLECT_ORDER_CHECK_EN
                if (int'(ab) != 0) err_exp = 1'b1;
`endif
                cur.data[DATA_W-1:0] = d;
                cur_cnt = 1;
            end else begin
                exp_q.push_back(cur);
            end
        end else begin
`ifdef RELEASE_COLLECT_ORDER_CHECK_EN
            if (int'(ab) != cur_cnt) err_exp = 1'b1;
`endif
            cur.data[cur_cnt*DATA_W +: DATA_W] = d;
            cur_cnt++;
            if (cur_cnt == BEATS) begin
                exp_q.push_back(cur);
                cur_cnt = 0;
            end
        end
    endtask

    // One clock cycle: drive inputs, check outputs, advance the model.
    task automatic step(input bit v, input logic [25:0] blk, input logic [5:0] xid,
                        input bit vol, input logic [2:0] rt, input logic [BW-1:0] ab,
                        input logic [DATA_W-1:0] d, input bit ordy, output bit acc);
        bit exp_valid, exp_rdy;
        @(negedge clk);
        io_in_valid               = v;
        io_in_bits_addr_block     = blk;
        io_in_bits_client_xact_id = xid;
        io_in_bits_voluntary      = vol;
        io_in_bits_r_type         = rt;
        io_in_bits_addr_beat      = ab;
        io_in_bits_data           = d;
        io_out_ready              = ordy;
        #1;
        exp_valid = (exp_q.size() != 0);
        exp_rdy   = !exp_valid || ordy;
        chk("out_valid", OW'(io_out_valid), OW'(exp_valid));
        chk("in_ready", OW'(io_in_ready), OW'(exp_rdy));
        chk("err", OW'(io_err), OW'(err_exp));
        if (exp_valid) begin
            chk("addr_block", OW'(io_out_bits_addr_block), OW'(exp_q[0].blk));
            chk("xact_id", OW'(io_out_bits_client_xact_id), OW'(exp_q[0].xid));
            chk("voluntary", OW'(io_out_bits_voluntary), OW'(exp_q[0].vol));
            chk("r_type", OW'(io_out_bits_r_type), OW'(exp_q[0].rt));
            chk("has_data", OW'(io_out_bits_has_data), OW'(exp_q[0].hd));
            chk("data", io_out_bits_data, exp_q[0].data);
        end
        acc = v && exp_rdy;
        if (exp_valid && ordy) void'(exp_q.pop_front());
        if (acc) model_beat(blk, xid, vol, rt, ab, d);
    endtask

    task automatic idle(input bit ordy, input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 26'h0, 6'h0, 1'b0, 3'd0, '0, '0, ordy, acc);
    endtask

    // Send up to nbeats beats of a release (all beats if data-carrying, one
    // otherwise). Later beats carry random header fields that must be ignored.
    task automatic send_release(input logic [2:0] rt, input logic [25:0] blk, input bit pat,
                                input int gap, input bit ordy, input logic [7:0] ab_seq,
                                input int nbeats);
        int n;
        n = (rt <= 3'd2) ? BEATS : 1;
        if (nbeats < n) n = nbeats;
        for (int k = 0; k < n; k++) begin
            bit acc;
            int tries;
            logic [DATA_W-1:0] d;
            logic [7:0] pb;
            pb = 8'h11 * 8'(k + 1);
            d  = pat ? {16{pb}} : rand_data();
            acc = 1'b0;
            tries = 0;
            while (!acc) begin
                if (k == 0)
                    step(1'b1, blk, 6'h15, 1'b1, rt, ab_seq[2*k +: 2], d,
                         (tries >= 4) ? 1'b1 : ordy, acc);
                else
                    step(1'b1, 26'($urandom), 6'($urandom), 1'($urandom), 3'($urandom),
                         ab_seq[2*k +: 2], d, (tries >= 4) ? 1'b1 : ordy, acc);
                tries++;
            end
            idle(ordy, gap);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n     = 1'b0;
        io_in_valid = 1'b0;
        #1;
        exp_q.delete();
        cur_cnt = 0;
        err_exp = 1'b0;
        chk("rst_out_valid", OW'(io_out_valid), OW'(1'b0));
        chk("rst_in_ready", OW'(io_in_ready), OW'(1'b1));
        chk("rst_err", OW'(io_err), OW'(1'b0));
        chk("rst_addr_block", OW'(io_out_bits_addr_block), '0);
        chk("rst_has_data", OW'(io_out_bits_has_data), '0);
        chk("rst_data", io_out_bits_data, '0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bit acc;
        do_reset();
        idle(1'b1, 2);

        // Four back-to-back data beats with fixed pattern
        send_release(3'd0, 26'h0123456, 1'b1, 0, 1'b1, 8'hE4, BEATS);
        idle(1'b1, 2);

        // Single no-data beat carrying a non-zero payload
        begin
            logic [DATA_W-1:0] ff;
            ff = '1;
            step(1'b1, 26'h2A5, 6'h3, 1'b0, 3'd4, '0, ff, 1'b1, acc);
        end
        idle(1'b1, 2);

        // Hold FULL with backpressure, then fire in and out together
        send_release(3'd1, 26'h1ABCDE, 1'b0, 0, 1'b0, 8'hE4, BEATS);
        for (int i = 0; i < 5; i++)
            step(1'b1, 26'h0777, 6'h2A, 1'b1, 3'd3, '0, rand_data(), 1'b0, acc);
        step(1'b1, 26'h0777, 6'h2A, 1'b1, 3'd3, '0, rand_data(), 1'b1, acc);
        step(1'b0, 26'h0, 6'h0, 1'b0, 3'd0, '0, '0, 1'b0, acc);
        idle(1'b1, 2);

        // Gaps of three idle cycles between beats
        send_release(3'd2, 26'h0F0F0F, 1'b0, 3, 1'b1, 8'hE4, BEATS);
        idle(1'b1, 2);

        // Reset after two beats, then a clean release
        send_release(3'd0, 26'h3333, 1'b0, 0, 1'b1, 8'hE4, 2);
        do_reset();
        send_release(3'd1, 26'h4444, 1'b0, 0, 1'b1, 8'hE4, BEATS);
        idle(1'b1, 2);

        // Out-of-order beat indices 0,2,1,3
        send_release(3'd0, 26'h5555, 1'b0, 0, 1'b1, 8'hD8, BEATS);
        idle(1'b1, 3);
        do_reset();

        // Randomised traffic with correct beat indices
        for (int i = 0; i < 400; i++) begin
            bit v, ordy;
            v    = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 7);
            step(v, 26'($urandom), 6'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
                 BW'(cur_cnt), rand_data(), ordy, acc);
        end
        idle(1'b1, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
